tone_scheduler: RTL and testbench

//  Shares one square-wave tone generator (17-bit period counter) between two requesters.

---
 rtl/tone_pkg.sv | 23 ++
 rtl/tone_divider.sv | 41 ++++
 rtl/tone_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_tone_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone scheduler.
//   tone_state_e : scheduler states (idle, playing tone, silent gap)
//   CNT_W        : period counter / half-period width
//   DUR_W        : tone-cycle count width
//   gap_cnt_w()  : width of a counter that must reach a given gap length
package tone_pkg;

    localparam int unsigned CNT_W              = 17;
    localparam int unsigned DUR_W              = 8;
    localparam int unsigned GAP_CYCLES_DEFAULT = 1000;
    localparam int unsigned MIN_HALF_DEFAULT   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } tone_state_e;

    function automatic int unsigned gap_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Clearable half-period counter with terminal compare.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   clr   : synchronous clear to 0 (wins over en)
//   en    : count enable
//   half  : terminal value + 1; must be >= 1 while en is high
//   tc    : combinational, high when enabled and the count sits at half-1
module tone_divider
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] half,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == (half - 1'b1));

    // Cleared at the compare, so the count never exceeds half-1 and cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_scheduler.sv
// Shares one square-wave tone generator between two requesters.
// Port 0 has fixed priority over port 1. Each accepted job plays ncyc full
// square cycles of period 2*half, then stays silent for GAP_CYCLES cycles
// before pulsing done.
//   clk, reset          : clock (rising edge), async active-high reset
//   req0/req1           : level requests, held until the matching ack
//   half0/half1         : half-period in clk cycles, sampled at accept
//   ncyc0/ncyc1         : full square cycles to play, sampled at accept
//   ack0/ack1           : one-cycle accept pulse
//   abort               : end the running job at the next edge
//   audio_out           : square-wave output
//   busy                : high whenever a job is in progress
//   done/done_src       : one-cycle end-of-job pulse and its requester
//   aborted             : valid with done, job was ended by abort
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT,
    parameter int unsigned MIN_HALF   = MIN_HALF_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [CNT_W-1:0] half0,
    input  logic [CNT_W-1:0] half1,
    input  logic [DUR_W-1:0] ncyc0,
    input  logic [DUR_W-1:0] ncyc1,
    input  logic             abort,
    output logic             ack0,
    output logic             ack1,
    output logic             audio_out,
    output logic             busy,
    output logic             done,
    output logic             done_src,
    output logic             aborted
);

    localparam int unsigned GAP_W = gap_cnt_w(GAP_CYCLES);

    tone_state_e      state_q, state_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic             src_q, src_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             audio_q, audio_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             done_q, done_d;
    logic             done_src_q, done_src_d;
    logic             aborted_q, aborted_d;

    logic             div_tc;
    logic             div_en;
    logic             div_clr;

    // Arbiter: port 0 wins; the losing request simply stays pending.
    logic             grant_src;
    logic [CNT_W-1:0] grant_half;
    logic [DUR_W-1:0] grant_ncyc;

    always_comb begin
        grant_src  = !req0;
        grant_half = req0 ? half0 : half1;
        grant_ncyc = req0 ? ncyc0 : ncyc1;
        if (grant_half < CNT_W'(MIN_HALF)) begin
            grant_half = CNT_W'(MIN_HALF);
        end
    end

    assign div_en  = (state_q == StPlay);
    assign div_clr = (state_q != StPlay) || abort;

    tone_divider u_divider (
        .clk   (clk),
        .reset (reset),
        .clr   (div_clr),
        .en    (div_en),
        .half  (half_q),
        .tc    (div_tc)
    );

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        rem_d      = rem_q;
        src_d      = src_q;
        gcnt_d     = gcnt_q;
        audio_d    = audio_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        done_d     = 1'b0;
        done_src_d = 1'b0;
        aborted_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                audio_d = 1'b0;
                // abort in idle suppresses a same-cycle grant
                if (!abort && (req0 || req1)) begin
                    half_d  = grant_half;
                    rem_d   = grant_ncyc;
                    src_d   = grant_src;
                    gcnt_d  = '0;
                    ack0_d  = !grant_src;
                    ack1_d  = grant_src;
                    state_d = (grant_ncyc == '0) ? StGap : StPlay;
                end
            end
            StPlay: begin
                if (abort) begin
                    audio_d    = 1'b0;
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                    done_src_d = src_q;
                    state_d    = StIdle;
                end else if (div_tc) begin
                    audio_d = !audio_q;
                    // Only the falling toggle completes a square cycle.
                    if (audio_q) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == DUR_W'(1)) begin
                            gcnt_d  = '0;
                            state_d = StGap;
                        end
                    end
                end
            end
            StGap: begin
                audio_d = 1'b0;
                if (abort) begin
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                    done_src_d = src_q;
                    state_d    = StIdle;
                end else if (gcnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    done_d     = 1'b1;
                    done_src_d = src_q;
                    state_d    = StIdle;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                audio_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            half_q     <= '0;
            rem_q      <= '0;
            src_q      <= 1'b0;
            gcnt_q     <= '0;
            audio_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done_q     <= 1'b0;
            done_src_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            rem_q      <= rem_d;
            src_q      <= src_d;
            gcnt_q     <= gcnt_d;
            audio_q    <= audio_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done_q     <= done_d;
            done_src_q <= done_src_d;
            aborted_q  <= aborted_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign audio_out = audio_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign done_src  = done_src_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler with a short gap. A job-level reference model
// predicts every output each cycle from elapsed time since accept.
module tb_tone_scheduler;
    import tone_pkg::*;

    localparam int unsigned GAP   = 8;
    localparam int unsigned MIN_H = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1, abort;
    logic [CNT_W-1:0] half0, half1;
    logic [DUR_W-1:0] ncyc0, ncyc1;
    logic             ack0, ack1, audio_out, busy, done, done_src, aborted;

    tone_scheduler #(
        .GAP_CYCLES (GAP),
        .MIN_HALF   (MIN_H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .half0     (half0),
        .half1     (half1),
        .ncyc0     (ncyc0),
        .ncyc1     (ncyc1),
        .abort     (abort),
        .ack0      (ack0),
        .ack1      (ack1),
        .audio_out (audio_out),
        .busy      (busy),
        .done      (done),
        .done_src  (done_src),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one job record plus this cycle's pulse outputs.
    bit          m_active;
    int unsigned m_t;
    int unsigned m_half;
    int unsigned m_ncyc;
    bit          m_src;
    bit          m_ack0, m_ack1, m_done, m_dsrc, m_abt;

    function automatic logic [6:0] model_outs();
        bit          aud;
        int unsigned tone_len;
        tone_len = 2 * m_half * m_ncyc;
        aud = m_active && (m_t < tone_len) && (((m_t / m_half) % 2) == 1);
        return {m_ack0, m_ack1, m_active, aud, m_done, m_dsrc, m_abt};
    endfunction

    function automatic logic [6:0] dut_outs();
        return {ack0, ack1, busy, audio_out, done, done_src, aborted};
    endfunction

    task automatic model_reset();
        m_active = 0; m_t = 0; m_half = 0; m_ncyc = 0; m_src = 0;
        m_ack0 = 0; m_ack1 = 0; m_done = 0; m_dsrc = 0; m_abt = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int unsigned h;
        m_ack0 = 0; m_ack1 = 0; m_done = 0; m_dsrc = 0; m_abt = 0;
        if (m_active) begin
            if (abort) begin
                m_active = 0; m_done = 1; m_abt = 1; m_dsrc = m_src;
            end else if (m_t + 1 == 2 * m_half * m_ncyc + GAP) begin
                m_active = 0; m_done = 1; m_dsrc = m_src;
            end else begin
                m_t++;
            end
        end else if (!abort && (req0 || req1)) begin
            m_src    = !req0;
            h        = req0 ? 32'(half0) : 32'(half1);
            m_half   = (h < MIN_H) ? MIN_H : h;
            m_ncyc   = req0 ? 32'(ncyc0) : 32'(ncyc1);
            m_t      = 0;
            m_active = 1;
            m_ack0   = req0;
            m_ack1   = !req0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("outs{ack0,ack1,busy,audio,done,src,abt}", 32'(dut_outs()), 32'(model_outs()));
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; abort = 0;
        half0 = '0; half1 = '0; ncyc0 = '0; ncyc1 = '0;
        model_reset();
        #12;
        check_eq("reset_outs", 32'(dut_outs()), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Basic tone: 3 cycles of period 8, then gap.
        req0 = 1; half0 = 4; ncyc0 = 3;
        tick();
        req0 = 0;
        repeat (40) tick();

        // Simultaneous requests: port 0 first, port 1 after done.
        req0 = 1; half0 = 3; ncyc0 = 2;
        req1 = 1; half1 = 5; ncyc1 = 1;
        tick();
        req0 = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (m_ack1) req1 = 0;
        end

        // Clamp and zero-length tone.
        req1 = 1; half1 = 0; ncyc1 = 0;
        tick();
        req1 = 0;
        repeat (12) tick();
        req1 = 1; half1 = 1; ncyc1 = 2;
        tick();
        req1 = 0;
        repeat (20) tick();

        // Abort during PLAY, then abort in idle blocks a grant.
        req0 = 1; half0 = 6; ncyc0 = 4;
        tick();
        req0 = 0;
        repeat (9) tick();
        abort = 1;
        tick();
        abort = 0;
        req0 = 1; half0 = 2; ncyc0 = 1; abort = 1;
        tick();
        abort = 0;
        tick();
        req0 = 0;
        repeat (16) tick();

        // Async reset mid-tone while audio is high.
        req0 = 1; half0 = 3; ncyc0 = 5;
        tick();
        req0 = 0;
        repeat (4) tick();
        check_eq("pre_reset_audio", 32'(audio_out), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_reset_outs", 32'(dut_outs()), 32'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        req0 = 1; half0 = 2; ncyc0 = 2;
        tick();
        req0 = 0;
        repeat (20) tick();

        // Largest half-period: no early toggle over a long stretch, then abort.
        req0 = 1; half0 = {CNT_W{1'b1}}; ncyc0 = 1;
        tick();
        req0 = 0;
        repeat (3000) tick();
        abort = 1;
        tick();
        abort = 0;
        tick();

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            if (m_ack0 || !req0) begin
                req0 = ($urandom_range(0, 7) == 0);
                half0 = CNT_W'($urandom_range(0, 6));
                ncyc0 = DUR_W'($urandom_range(0, 4));
            end
            if (m_ack1 || !req1) begin
                req1 = ($urandom_range(0, 7) == 0);
                half1 = CNT_W'($urandom_range(0, 6));
                ncyc1 = DUR_W'($urandom_range(0, 4));
            end
            abort = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
